// File: rtl/step_debouncer_pkg.sv
// Shared definitions for the front-panel clock control path: step FSM
// encoding and the default timing constants used by the clock wrapper.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } step_state_t;

  localparam logic [31:0] DEFAULT_DEBOUNCE_CYCLES   = 32'd1000000;
  localparam logic [31:0] DEFAULT_STEP_PULSE_CYCLES = 32'd16;

endpackage : clock_ctrl_pkg

// File: rtl/step_debouncer_if.sv
// Button-side and clock-module-side signals of the step debouncer, bundled
// so the top level and its environment share one port list.
interface step_debouncer_if;
  import clock_ctrl_pkg::*;

  // No handshake: raw buttons are free-running asynchronous levels, and every
  // output is a registered level or pulse the consumer samples on each clock.
  logic        i_BTN_TOGGLE;
  logic        i_BTN_STEP;
  logic        i_BTN_HALT;
  logic        o_STEP_TOGGLE;
  logic        o_STEP_CLOCK;
  logic        o_HALT;
  logic        o_MANUAL;
  step_state_t o_DBG_STATE;

  modport slave (
    input  i_BTN_TOGGLE, i_BTN_STEP, i_BTN_HALT,
    output o_STEP_TOGGLE, o_STEP_CLOCK, o_HALT, o_MANUAL, o_DBG_STATE
  );

  modport master (
    output i_BTN_TOGGLE, i_BTN_STEP, i_BTN_HALT,
    input  o_STEP_TOGGLE, o_STEP_CLOCK, o_HALT, o_MANUAL, o_DBG_STATE
  );

endinterface : step_debouncer_if

// File: rtl/step_debouncer_button.sv
// One button channel: 2-flop synchronizer, persistence-count debouncer and a
// rising-edge detector on the debounced level.
module button_debouncer
  import clock_ctrl_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_SYS_CLOCK,
  input  logic i_RESET_n,
  input  logic i_RAW,
  output logic o_LEVEL,
  output logic o_RISE
);

  logic [1:0]  sync_q;
  logic        level_q, level_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      sync_q  <= {sync_q[0], i_RAW};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample matching the current level restarts the count, so only an
  // uninterrupted run of differing samples can flip the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = 32'd0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  assign o_LEVEL = level_q;
  // Flags the edge at which the level is about to rise, letting the top
  // register its toggle response on that same edge.
  assign o_RISE  = level_d & ~level_q;

endmodule : button_debouncer

// File: rtl/step_debouncer.sv
// Front-panel conditioning for the clock generator: debounced halt level,
// one-cycle toggle pulse with manual-mode flag, and fixed-width step pulses.
module step_debouncer
  import clock_ctrl_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [31:0] STEP_PULSE_CYCLES = DEFAULT_STEP_PULSE_CYCLES
) (
  input  logic         i_SYS_CLOCK,
  input  logic         i_RESET_n,
  step_debouncer_if.slave bus
);

  logic tog_level, tog_rise;
  logic step_level, step_rise;
  logic halt_level, halt_rise;
  logic unused_levels;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_toggle (
    .i_SYS_CLOCK (i_SYS_CLOCK),
    .i_RESET_n   (i_RESET_n),
    .i_RAW       (bus.i_BTN_TOGGLE),
    .o_LEVEL     (tog_level),
    .o_RISE      (tog_rise)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .i_SYS_CLOCK (i_SYS_CLOCK),
    .i_RESET_n   (i_RESET_n),
    .i_RAW       (bus.i_BTN_STEP),
    .o_LEVEL     (step_level),
    .o_RISE      (step_rise)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (
    .i_SYS_CLOCK (i_SYS_CLOCK),
    .i_RESET_n   (i_RESET_n),
    .i_RAW       (bus.i_BTN_HALT),
    .o_LEVEL     (halt_level),
    .o_RISE      (halt_rise)
  );

  assign unused_levels = tog_level ^ step_level ^ halt_rise;

  step_state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        step_clk_q, step_clk_d;
  logic        manual_q, manual_d;
  logic        toggle_q;
  logic        step_rise_q;

  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      step_clk_q  <= 1'b0;
      manual_q    <= 1'b0;
      toggle_q    <= 1'b0;
      step_rise_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_clk_q  <= step_clk_d;
      manual_q    <= manual_d;
      toggle_q    <= tog_rise;
      step_rise_q <= step_rise;
    end
  end

  assign manual_d = manual_q ^ tog_rise;

  // PULSE and GAP both run STEP_PULSE_CYCLES long and ignore every input, so
  // a pulse is never cut short and presses during them are simply lost.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (step_rise_q && manual_q && !halt_level) begin
          state_d = ST_PULSE;
          cnt_d   = STEP_PULSE_CYCLES - 32'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 32'd0) begin
          state_d = ST_GAP;
          cnt_d   = STEP_PULSE_CYCLES - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 32'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  always_comb begin
    step_clk_d = (state_d == ST_PULSE);
  end

  assign bus.o_STEP_TOGGLE = toggle_q;
  assign bus.o_STEP_CLOCK  = step_clk_q;
  assign bus.o_HALT        = halt_level;
  assign bus.o_MANUAL      = manual_q;
  assign bus.o_DBG_STATE   = state_q;

endmodule : step_debouncer

// File: doc/step_debouncer.md
# step_debouncer

Conditions the raw front-panel pushbuttons that drive the system clock generator (toggle, step, halt) into clean, synchronous control signals. It sits directly upstream of the clock module.
- The clock module's manual-step toggle input is positive-edge triggered, so this block produces exactly one rising edge per press.
- The step input is sampled on every system clock edge, so this block produces fixed-width step pulses.
- The halt input is level-sensitive, so this block produces a bounce-free level.
- All outputs are registered in the i_SYS_CLOCK domain.

## Interface
- DEBOUNCE_CYCLES, 32'd1000000: consecutive cycles a synchronized input must differ from its debounced state before that state flips; legal range 1..2^32-1.
- STEP_PULSE_CYCLES, 32'd16: high time of o_STEP_CLOCK, and the minimum low time after it, in cycles; legal range 1..2^32-1.
- i_SYS_CLOCK  in  1  system clock; sole clock.
- i_RESET_n  in  1  asynchronous, active-low reset.
- i_BTN_TOGGLE  in  1  raw toggle button, active-high, asynchronous, bouncy.
- i_BTN_STEP  in  1  raw step button, same properties.
- i_BTN_HALT  in  1  raw halt switch, same properties.
- o_STEP_TOGGLE  out  1  one-cycle pulse per debounced toggle press; feeds the clock module's toggle input.
- o_STEP_CLOCK  out  1  STEP_PULSE_CYCLES-wide pulse per accepted step press; feeds the clock module's step input.
- o_HALT  out  1  debounced halt level; feeds the clock module's halt input.
- o_MANUAL  out  1  local mirror of manual-step mode, for a status LED.

## Operation
- Reset values: all outputs 0, debounced states 0, counters 0, step FSM in IDLE.
- Each button channel has three stages:
  - 2-flop synchronizer.
  - Debounce counter: clears whenever the synchronized value equals the debounced state. Otherwise it increments; when it reaches DEBOUNCE_CYCLES, the debounced state takes the synchronized value and the counter clears.
  - Rising-edge detector on the debounced state.
- Glitches shorter than DEBOUNCE_CYCLES are rejected completely. Any return to the debounced value restarts the count.
- o_HALT equals the debounced halt state.
- On a toggle rising edge:
  - o_STEP_TOGGLE is high for exactly one cycle.
  - o_MANUAL inverts on the same edge.
- Step FSM has three states: IDLE, PULSE, GAP.
  - IDLE -> PULSE on a step rising edge when o_MANUAL=1 and o_HALT=0. The transition loads the counter with STEP_PULSE_CYCLES-1, and o_STEP_CLOCK is registered high on that edge.
  - PULSE: o_STEP_CLOCK=1; the counter decrements. When the counter is 0, go to GAP and reload STEP_PULSE_CYCLES-1.
  - GAP: o_STEP_CLOCK=0; the counter decrements. When the counter is 0, go to IDLE.
- Step edges that arrive in PULSE or GAP are dropped, not queued.
- Step edges that arrive while o_MANUAL=0 or o_HALT=1 are dropped.
- A toggle or halt that occurs during PULSE does not truncate the pulse; no runt pulses are allowed.
- Counter arithmetic: all counters are 32-bit unsigned and saturate-free by construction, since they clear or reload before overflow.

## Timing
- Cycle 0 is the first i_SYS_CLOCK edge at which a raw input is sampled at a new level that then stays stable.
  - The debounced state flips at edge DEBOUNCE_CYCLES+2.
  - o_HALT and o_MANUAL change at that edge.
  - o_STEP_TOGGLE is high during the cycle that follows.
  - o_STEP_CLOCK rises at edge DEBOUNCE_CYCLES+3.
- o_STEP_CLOCK is high for exactly STEP_PULSE_CYCLES cycles, then low for at least STEP_PULSE_CYCLES cycles.
- The earliest accepted step rising edge is therefore 2*STEP_PULSE_CYCLES cycles after the previous one.
- Release edges produce no pulses.
- Reset asserted mid-pulse forces o_STEP_CLOCK low asynchronously and returns the FSM to IDLE.
- Raw inputs held high through reset release:
  - The debounced state flips DEBOUNCE_CYCLES+2 cycles after release.
  - This is treated as a press and produces edges.

## Structure
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports i_SYS_CLOCK, i_RESET_n, i_RAW, o_LEVEL, o_RISE), instantiated three times.
- Shared package clock_ctrl_pkg holds:
  - the step FSM state encoding (IDLE=2'd0, PULSE=2'd1, GAP=2'd2);
  - the default DEBOUNCE_CYCLES and STEP_PULSE_CYCLES constants, reused by the top-level clock wrapper.
- The top level holds the manual flag, the step FSM and the step counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and STEP_PULSE_CYCLES=3.
- Reset: i_RESET_n low with all buttons high -> all outputs 0. Hold the buttons after release -> o_HALT=1 at edge 6, o_MANUAL=1 at edge 6, single o_STEP_TOGGLE cycle.
- Bounce: i_BTN_HALT toggles every 2 cycles for 20 cycles, then holds 1 -> o_HALT stays 0 until 6 edges after the final stable sample; never glitches.
- Step in auto mode: o_MANUAL=0, press step -> o_STEP_CLOCK stays 0.
- Step in manual mode: o_MANUAL=1, clean press -> o_STEP_CLOCK high at edge 7 for exactly 3 cycles, then low. A second debounced press arriving 2 cycles after the fall is dropped; a press arriving after the GAP state ends produces a second 3-cycle pulse.
- Halt interaction: o_HALT=1 and manual, press step -> no pulse. Halt asserted mid-pulse -> pulse still completes 3 cycles.
- Async reset mid-pulse: pull i_RESET_n low in cycle 2 of PULSE -> o_STEP_CLOCK 0 immediately, o_MANUAL 0, FSM in IDLE after release.
